// File: rtl/dec_pkg.sv
// Shared MIPS32 decode definitions: opcode/funct codes, control bundle layout,
// multiplier FSM states and instruction-class helpers.
package dec_pkg;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06;
  localparam logic [5:0] OP_BGTZ     = 6'h07;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LH       = 6'h21;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_LBU      = 6'h24;
  localparam logic [5:0] OP_LHU      = 6'h25;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SH       = 6'h29;
  localparam logic [5:0] OP_SW       = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [5:0] FN2_MADD  = 6'h00;
  localparam logic [5:0] FN2_MADDU = 6'h01;
  localparam logic [5:0] FN2_MUL   = 6'h02;
  localparam logic [5:0] FN2_MSUB  = 6'h04;
  localparam logic [5:0] FN2_MSUBU = 6'h05;
  localparam logic [5:0] FN2_CLZ   = 6'h20;
  localparam logic [5:0] FN2_CLO   = 6'h21;

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef struct packed {
    logic regDst;
    logic branch;
    logic jump;
    logic memRead;
    logic memToReg;
    logic aluOp;
    logic mulOp;
    logic memWrite;
    logic aluSrc;
    logic regWrite;
    logic shiftSel;
    logic illegal;
  } ctrl_t;

  typedef enum logic {MUL_IDLE, MUL_BUSY} mul_state_t;

  function automatic logic is_mul_class(input logic [5:0] op, input logic [5:0] fn);
    logic r;
    r = 1'b0;
    if (op == OP_SPECIAL)
      r = (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_MTHI) || (fn == FN_MTLO);
    else if (op == OP_SPECIAL2)
      r = (fn == FN2_MADD) || (fn == FN2_MADDU) || (fn == FN2_MSUB) ||
          (fn == FN2_MSUBU) || (fn == FN2_MUL);
    return r;
  endfunction

  function automatic logic is_hilo_read(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_SPECIAL) && ((fn == FN_MFHI) || (fn == FN_MFLO));
  endfunction

endpackage

// File: rtl/decode_stage_comb.sv
// Purely combinational MIPS32 decode table: instruction -> control bundle,
// function code, destination index and extended immediate (J/JAL carry the target).
module decode_comb
  import dec_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic [5:0]  func,
  output logic [4:0]  rd,
  output logic [31:0] imm
);

  logic [5:0]  opcode;
  logic [5:0]  fn;
  logic [31:0] immSext;
  logic [31:0] immZext;
  logic        bad;

  assign opcode  = instr[31:26];
  assign fn      = instr[5:0];
  assign immSext = {{16{instr[15]}}, instr[15:0]};
  assign immZext = {16'h0000, instr[15:0]};
  assign rd      = (opcode == OP_JAL) ? LINK_REG : instr[15:11];

  always_comb begin
    ctrl = '0;
    func = '0;
    imm  = '0;
    bad  = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        case (fn)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT, FN_SLTU, FN_MFHI, FN_MFLO: begin
            ctrl.regDst   = 1'b1;
            ctrl.aluOp    = 1'b1;
            ctrl.regWrite = 1'b1;
            func          = fn;
          end
          FN_MULT, FN_MULTU, FN_MTHI, FN_MTLO: begin
            ctrl.aluOp = 1'b1;
            func       = fn;
          end
          FN_JR:   ctrl.jump = 1'b1;
          FN_JALR: begin
            ctrl.jump     = 1'b1;
            ctrl.regWrite = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      OP_SPECIAL2: begin
        case (fn)
          FN2_MUL, FN2_CLZ, FN2_CLO: begin
            ctrl.regDst   = 1'b1;
            ctrl.mulOp    = 1'b1;
            ctrl.regWrite = 1'b1;
            func          = fn;
          end
          FN2_MADD, FN2_MADDU, FN2_MSUB, FN2_MSUBU: begin
            ctrl.mulOp = 1'b1;
            func       = fn;
          end
          default: bad = 1'b1;
        endcase
      end
      // Immediate ALU ops borrow the R-type function code of their register twin
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.aluOp    = 1'b1;
        ctrl.aluSrc   = 1'b1;
        ctrl.regWrite = 1'b1;
        imm           = immSext;
        case (opcode)
          OP_ADDI:  func = FN_ADD;
          OP_ADDIU: func = FN_ADDU;
          OP_SLTI:  func = FN_SLT;
          OP_SLTIU: func = FN_SLTU;
          OP_ANDI: begin func = FN_AND; imm = immZext; end
          OP_ORI:  begin func = FN_OR;  imm = immZext; end
          OP_XORI: begin func = FN_XOR; imm = immZext; end
          default: begin
            func          = FN_OR;
            ctrl.shiftSel = 1'b1;
            imm           = {instr[15:0], 16'h0000};
          end
        endcase
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        ctrl.memRead  = 1'b1;
        ctrl.memToReg = 1'b1;
        ctrl.aluSrc   = 1'b1;
        ctrl.regWrite = 1'b1;
        func          = FN_ADDU;
        imm           = immSext;
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl.memWrite = 1'b1;
        ctrl.aluSrc   = 1'b1;
        func          = FN_ADDU;
        imm           = immSext;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        ctrl.branch = 1'b1;
        func        = FN_SUB;
        imm         = immSext;
      end
      OP_J: begin
        ctrl.jump = 1'b1;
        imm       = {6'b000000, instr[25:0]};
      end
      OP_JAL: begin
        ctrl.jump     = 1'b1;
        ctrl.regWrite = 1'b1;
        imm           = {6'b000000, instr[25:0]};
      end
      default: bad = 1'b1;
    endcase
    // Unknown encodings still flow downstream, but with only the flag raised
    if (bad) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
      func         = '0;
      imm          = '0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered MIPS32 decode stage with valid/ready handshake and HI/LO hazard
// tracking. Optional DEC_ILLEGAL_TRAP_EN: halt intake after an Illegal bundle drains.
module decode_stage
  import dec_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = $clog2(MUL_LAT + 1)
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_ctrl,
  output logic [5:0]  out_func,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_shamt,
  output logic [31:0] out_imm,
  output logic        mul_busy
);

  ctrl_t       decCtrl_p0;
  logic [5:0]  decFunc_p0;
  logic [4:0]  decRd_p0;
  logic [31:0] decImm_p0;

  ctrl_t       ctrl_p1;
  logic [5:0]  func_p1;
  logic [4:0]  rs_p1;
  logic [4:0]  rt_p1;
  logic [4:0]  rd_p1;
  logic [4:0]  shamt_p1;
  logic [31:0] imm_p1;
  logic        vld_p1;

  mul_state_t     mulState;
  mul_state_t     mulStateNext;
  logic [CNT_W-1:0] mulCnt;
  logic [CNT_W-1:0] mulCntNext;

  logic inMul;
  logic inHiloRead;
  logic hazard;
  logic trapBlock;
  logic accept;

  decode_comb uDecode (
    .instr (in_instr),
    .ctrl  (decCtrl_p0),
    .func  (decFunc_p0),
    .rd    (decRd_p0),
    .imm   (decImm_p0)
  );

  assign inMul      = is_mul_class(in_instr[31:26], in_instr[5:0]);
  assign inHiloRead = is_hilo_read(in_instr[31:26], in_instr[5:0]);
  assign hazard     = (mulState == MUL_BUSY) && (inMul || inHiloRead);
  assign in_ready   = (!vld_p1 || out_ready) && !hazard && !trapBlock;
  assign accept     = in_valid && in_ready;

`ifdef DEC_ILLEGAL_TRAP_EN
  logic trapped;

  // Block intake as soon as an Illegal bundle sits in the output register, so
  // nothing follows it into the pipe once it drains.
  assign trapBlock = trapped || (vld_p1 && ctrl_p1.illegal);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)
      trapped <= 1'b0;
    else if (vld_p1 && out_ready && ctrl_p1.illegal)
      trapped <= 1'b1;
  end
`else
  assign trapBlock = 1'b0;
`endif

  always_comb begin
    mulStateNext = mulState;
    mulCntNext   = mulCnt;
    case (mulState)
      MUL_IDLE: begin
        if (accept && inMul) begin
          mulStateNext = MUL_BUSY;
          mulCntNext   = CNT_W'(MUL_LAT);
        end
      end
      MUL_BUSY: begin
        if (mulCnt == CNT_W'(1)) begin
          mulStateNext = MUL_IDLE;
          mulCntNext   = '0;
        end else begin
          mulCntNext = mulCnt - CNT_W'(1);
        end
      end
      default: begin
        mulStateNext = MUL_IDLE;
        mulCntNext   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      mulState <= MUL_IDLE;
      mulCnt   <= '0;
    end else begin
      mulState <= mulStateNext;
      mulCnt   <= mulCntNext;
    end
  end

  // Stage boundary p0 -> p1: decoded bundle is captured on accept and held otherwise
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      vld_p1   <= 1'b0;
      ctrl_p1  <= '0;
      func_p1  <= '0;
      rs_p1    <= '0;
      rt_p1    <= '0;
      rd_p1    <= '0;
      shamt_p1 <= '0;
      imm_p1   <= '0;
    end else begin
      if (accept) begin
        vld_p1   <= 1'b1;
        ctrl_p1  <= decCtrl_p0;
        func_p1  <= decFunc_p0;
        rs_p1    <= in_instr[25:21];
        rt_p1    <= in_instr[20:16];
        rd_p1    <= decRd_p0;
        shamt_p1 <= in_instr[10:6];
        imm_p1   <= decImm_p0;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_ctrl  = ctrl_p1;
  assign out_func  = func_p1;
  assign out_rs    = rs_p1;
  assign out_rt    = rt_p1;
  assign out_rd    = rd_p1;
  assign out_shamt = shamt_p1;
  assign out_imm   = imm_p1;
  assign mul_busy  = (mulCnt != '0);

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered MIPS32 decode stage between fetch and execute, with a valid/ready handshake on both sides.
- Converts a 32-bit instruction into a registered control bundle plus register indices and an extended immediate.
- Tracks multiplier/HI-LO occupancy for a parametrised multiply latency and stalls dependent instructions.
- Flags illegal encodings.

Parameters:
- MUL_LAT, 4, cycles the multiplier is busy after a multiply-class instruction issues (1..15).
- CNT_W, $clog2(MUL_LAT+1), busy-counter width (derived; do not override).

Ports:
- clock  in  1  system clock, rising edge
- nreset  in  1  asynchronous active-low reset
- in_valid  in  1  fetch holds a valid instruction
- in_instr  in  32  instruction word
- in_ready  out  1  stage accepts in_instr this cycle
- out_valid  out  1  registered decode bundle valid
- out_ready  in  1  execute consumes bundle this cycle
- out_ctrl  out  12  {RegDst,Branch,Jump,MemRead,MemtoReg,ALUOp,MULOp,MemWrite,ALUSrc,RegWrite,ShiftSel,Illegal}
- out_func  out  6  ALU/MUL function code
- out_rs, out_rt, out_rd  out  5 each  register indices (out_rd=31 for JAL)
- out_shamt  out  5  shift amount
- out_imm  out  32  extended immediate
- mul_busy  out  1  multiplier occupied (counter != 0)

Behaviour:
- Reset (nreset low, asynchronous):
  - out_valid=0; all out_* = 0; busy counter=0; mul_busy=0; FSM=MUL_IDLE.
  - Reset mid-transfer discards the held bundle and any in-flight multiply.
- Handshake:
  - accept = in_valid & in_ready.
  - in_ready = (!out_valid | out_ready) & !hazard.
  - On accept, the output register loads the decode next edge (latency 1); out_valid=1.
  - If out_ready & !accept: out_valid clears.
  - Bundle is held stable while out_valid & !out_ready.
  - in_ready does not depend combinationally on in_valid.
- Multiply-class instructions: MULT, MULTU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO, MUL.
- HI/LO readers: MFHI, MFLO.
- hazard = (FSM==MUL_BUSY) & incoming instruction is multiply-class or a HI/LO reader.
- FSM:
  - MUL_IDLE -> MUL_BUSY on accept of a multiply-class instruction; counter loads MUL_LAT.
  - MUL_BUSY: counter decrements each cycle; at counter==1 -> MUL_IDLE (counter 0).
  - Non-multiply instructions pass freely during MUL_BUSY.
- Decode table (all unlisted controls 0):
  - R-type ALU ops: RegDst, ALUOp, RegWrite; Func=funct.
  - MULT/MULTU/MTHI/MTLO: ALUOp only.
  - MFHI/MFLO: RegDst, ALUOp, RegWrite.
  - SPECIAL2 CLO/CLZ/MUL: RegDst, MULOp, RegWrite, with their own Func codes.
  - MADD/MADDU/MSUB/MSUBU: MULOp only.
  - I-type arith/logic (ADDI, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU): ALUOp, ALUSrc, RegWrite; Func = matching R-type code.
  - LUI: adds ShiftSel.
  - Loads: MemRead, MemtoReg, ALUSrc, RegWrite; Func=ADDU.
  - Stores: MemWrite, ALUSrc; Func=ADDU.
  - BEQ/BNE/BLEZ/BGTZ: Branch; Func=SUB.
  - J/JR: Jump.
  - JAL/JALR: Jump, RegWrite.
- Immediate extension:
  - Sign-extended for arith, SLTI, SLTIU, loads, stores, branches.
  - Zero-extended for ANDI/ORI/XORI.
  - LUI: imm<<16.
- Illegal: unknown opcode or funct -> Illegal=1, all other controls 0; the instruction still flows through.

Optional Feature:
- DEC_ILLEGAL_TRAP_EN defined:
  - After an Illegal bundle is accepted downstream, in_ready stays 0 until reset.
  - out_valid stays 0 after that bundle.
- Undefined: Illegal is informational only; the pipeline continues.

Decomposition:
- Package dec_pkg:
  - opcode/funct localparams;
  - ctrl_t packed struct matching out_ctrl;
  - mul_state_t enum {MUL_IDLE, MUL_BUSY};
  - is_mul_class(), is_hilo_read() functions.
- Sub-module decode_comb: pure combinational table instr -> ctrl/func/imm. decode_stage owns the registers, FSM and handshake.

Test Plan:
- ADD $3,$1,$2 (0x00221820), out_ready=1 -> next cycle out_valid=1, RegDst/ALUOp/RegWrite=1, func=0x20, rd=3.
- MULT (0x00220018) then MFLO $4 (0x00002012) back-to-back, MUL_LAT=4:
  - in_ready low 4 cycles, mul_busy high 4 cycles;
  - MFLO accepted on cycle 5 with RegWrite=1.
- ADDI $2,$1,-1 (0x2022FFFF) -> out_imm=0xFFFFFFFF, ALUSrc=1; ORI with 0xFFFF -> out_imm=0x0000FFFF.
- LW $5,8($1) (0x8C250008) with out_ready=0 for 3 cycles:
  - bundle stable, in_ready=0;
  - released on out_ready=1; MemRead/MemtoReg=1.
- 0xFC000000 -> Illegal=1, other controls 0; with DEC_ILLEGAL_TRAP_EN, in_ready stays 0 afterward.
- nreset asserted during MUL_BUSY -> mul_busy=0, out_valid=0 immediately, in_ready=1 after release.
